// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan sequencer.
//   state_t : sequencer states
//   NCH     : number of mux channels scanned per frame
//   ch_sel  : channel index -> {s1, s0} select encoding of the mux decode
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int unsigned NCH = 4;

  // The mux decodes s1 as the low channel bit and s0 as the high one.
  function automatic logic [1:0] ch_sel(input logic [1:0] ch);
    return {ch[0], ch[1]};
  endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: selects y0..y3 in turn, dwells DWELL cycles
// on each, samples the mux output once per channel and publishes a 4-bit
// frame with a one-cycle valid pulse. Single-shot or continuous.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : begin a scan (only looked at in IDLE)
//   cont       : continuous mode (only looked at in DONE)
//   mux_i      : mux output I
//   s0, s1, en : registered mux select / enable
//   sample     : last completed frame, bit k = y_k
//   valid      : one-cycle pulse when sample updates
//   busy       : high in SETTLE and DONE
//   frame_cnt  : completed-frame count, wraps modulo 2^FCW
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2,
  parameter int unsigned FCW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cont,
  input  logic           mux_i,
  output logic           s0,
  output logic           s1,
  output logic           en,
  output logic [3:0]     sample,
  output logic           valid,
  output logic           busy,
  output logic [FCW-1:0] frame_cnt
);

  localparam logic [3:0] DC_RELOAD = 4'(DWELL - 1);

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [3:0]       dc_q, dc_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic             s0_q, s0_d, s1_q, s1_d, en_q, en_d;
  logic [NCH-1:0]   sample_q, sample_d;
  logic             valid_q, valid_d, busy_q, busy_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      dc_q        <= '0;
      shadow_q    <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      en_q        <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dc_q        <= dc_d;
      shadow_q    <= shadow_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      en_q        <= en_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dc_d        = dc_q;
    shadow_d    = shadow_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    en_d        = en_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        s0_d   = 1'b0;
        s1_d   = 1'b0;
        if (start) begin
          state_d  = ST_SETTLE;
          ch_d     = '0;
          dc_d     = DC_RELOAD;
          shadow_d = '0;
          en_d     = 1'b1;
          busy_d   = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (dc_q != 4'd0) begin
          dc_d = dc_q - 4'd1;
        end else begin
          shadow_d[ch_q] = mux_i;
          if (ch_q != 2'd3) begin
            ch_d         = ch_q + 2'd1;
            dc_d         = DC_RELOAD;
            {s1_d, s0_d} = ch_sel(ch_q + 2'd1);
          end else begin
            // Last capture: publish the frame with channel 3 merged in on
            // this same edge so sample never shows a partial frame.
            state_d      = ST_DONE;
            en_d         = 1'b0;
            {s1_d, s0_d} = 2'b00;
            sample_d     = shadow_d;
            valid_d      = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (cont) begin
          state_d      = ST_SETTLE;
          ch_d         = '0;
          dc_d         = DC_RELOAD;
          shadow_d     = '0;
          en_d         = 1'b1;
          {s1_d, s0_d} = ch_sel(2'd0);
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign s0        = s0_q;
  assign s1        = s1_q;
  assign en        = en_q;
  assign sample    = sample_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl. Three instances cover DWELL=2,
// DWELL=1 and a 2-bit frame counter; each drives a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // instance A: DWELL=2, FCW=8
  logic a_start, a_cont, a_mux_i, a_s0, a_s1, a_en, a_valid, a_busy;
  logic [3:0] a_y, a_sample;
  logic [7:0] a_cnt;
  // instance B: DWELL=1, FCW=8
  logic b_start, b_cont, b_mux_i, b_s0, b_s1, b_en, b_valid, b_busy;
  logic [3:0] b_y, b_sample;
  logic [7:0] b_cnt;
  // instance C: DWELL=1, FCW=2
  logic c_start, c_cont, c_mux_i, c_s0, c_s1, c_en, c_valid, c_busy;
  logic [3:0] c_y, c_sample;
  logic [1:0] c_cnt;

  // Mux model: channel = {s0, s1}, output forced low when disabled.
  assign a_mux_i = a_en & a_y[{a_s0, a_s1}];
  assign b_mux_i = b_en & b_y[{b_s0, b_s1}];
  assign c_mux_i = c_en & c_y[{c_s0, c_s1}];

  mux_scan_ctrl #(.DWELL(2), .FCW(8)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .cont(a_cont), .mux_i(a_mux_i),
    .s0(a_s0), .s1(a_s1), .en(a_en), .sample(a_sample), .valid(a_valid),
    .busy(a_busy), .frame_cnt(a_cnt));

  mux_scan_ctrl #(.DWELL(1), .FCW(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .cont(b_cont), .mux_i(b_mux_i),
    .s0(b_s0), .s1(b_s1), .en(b_en), .sample(b_sample), .valid(b_valid),
    .busy(b_busy), .frame_cnt(b_cnt));

  mux_scan_ctrl #(.DWELL(1), .FCW(2)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .cont(c_cont), .mux_i(c_mux_i),
    .s0(c_s0), .s1(c_s1), .en(c_en), .sample(c_sample), .valid(c_valid),
    .busy(c_busy), .frame_cnt(c_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] y;
    logic [3:0] prev;
    logic [3:0] exp;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [4];
  logic [1:0] exp_sel [4];

  initial begin
    int unsigned vcount;
    int unsigned ecnt;
    logic ev;

    vecs[0] = '{y: 4'b1111, prev: 4'b0000, exp: 4'b1111, cnt: 8'd1};
    vecs[1] = '{y: 4'b0000, prev: 4'b1111, exp: 4'b0000, cnt: 8'd2};
    vecs[2] = '{y: 4'b1010, prev: 4'b0000, exp: 4'b1010, cnt: 8'd3};
    vecs[3] = '{y: 4'b0101, prev: 4'b1010, exp: 4'b0101, cnt: 8'd4};
    exp_sel[0] = 2'b00; exp_sel[1] = 2'b10; exp_sel[2] = 2'b01; exp_sel[3] = 2'b11;

    a_start = 0; a_cont = 0; a_y = '0;
    b_start = 0; b_cont = 0; b_y = '0;
    c_start = 0; c_cont = 0; c_y = '0;
    rst = 1'b1;
    tick(); tick();
    check("rst_en", 32'(a_en), 0);
    check("rst_sel", 32'({a_s1, a_s0}), 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_sample", 32'(a_sample), 0);
    check("rst_cnt", 32'(a_cnt), 0);
    rst = 1'b0;
    tick();

    // Single shot, DWELL=2, y0..y3 = 1,0,1,1
    a_y = 4'b1101; a_cont = 0; a_start = 1;
    tick();            // t0
    a_start = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      check("ss_en", 32'(a_en), 1);
      check("ss_busy", 32'(a_busy), 1);
      check("ss_valid_early", 32'(a_valid), 0);
      check("ss_sel", 32'({a_s1, a_s0}), 32'(exp_sel[i/2]));
    end
    tick();            // t0+8
    check("ss_valid", 32'(a_valid), 1);
    check("ss_en_off", 32'(a_en), 0);
    check("ss_sample", 32'(a_sample), 32'(4'b1101));
    check("ss_cnt", 32'(a_cnt), 1);
    tick();            // t0+9
    check("ss_valid_drop", 32'(a_valid), 0);
    check("ss_idle_busy", 32'(a_busy), 0);
    check("ss_sample_hold", 32'(a_sample), 32'(4'b1101));

    // Reset mid-scan, 3 cycles after start
    a_start = 1;
    tick();            // t0
    a_start = 0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rst_en", 32'(a_en), 0);
    check("mid_rst_busy", 32'(a_busy), 0);
    check("mid_rst_sel", 32'({a_s1, a_s0}), 0);
    check("mid_rst_sample", 32'(a_sample), 0);
    check("mid_rst_cnt", 32'(a_cnt), 0);
    tick();
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_valid) vcount++;
    end
    check("mid_rst_no_valid", vcount, 0);
    check("mid_rst_cnt_after", 32'(a_cnt), 0);

    // Table: frames with inputs changing between them
    for (int v = 0; v < 4; v++) begin
      a_y = vecs[v].y; a_start = 1;
      tick();          // t0
      a_start = 0;
      for (int i = 0; i < 7; i++) tick();
      check("tbl_pre_valid", 32'(a_valid), 0);
      check("tbl_hold", 32'(a_sample), 32'(vecs[v].prev));
      tick();          // t0+8
      check("tbl_valid", 32'(a_valid), 1);
      check("tbl_sample", 32'(a_sample), 32'(vecs[v].exp));
      check("tbl_cnt", 32'(a_cnt), 32'(vecs[v].cnt));
      tick();
      check("tbl_idle", 32'(a_busy), 0);
    end

    // start during SETTLE of ch2 is ignored
    a_y = 4'b1011; a_start = 1;
    tick();            // t0
    a_start = 0;
    for (int i = 0; i < 5; i++) tick();   // t0+5, ch2 selected
    check("ign_sel_ch2", 32'({a_s1, a_s0}), 32'(2'b01));
    a_start = 1;
    tick();            // t0+6
    a_start = 0;
    tick();            // t0+7
    check("ign_no_early", 32'(a_valid), 0);
    tick();            // t0+8
    check("ign_valid", 32'(a_valid), 1);
    check("ign_sample", 32'(a_sample), 32'(4'b1011));
    check("ign_cnt", 32'(a_cnt), 5);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (a_valid) vcount++;
    end
    check("ign_no_second", vcount, 0);
    check("ign_busy", 32'(a_busy), 0);

    // Continuous, DWELL=1, cont dropped mid third frame
    b_y = 4'b0110; b_cont = 1; b_start = 1;
    tick();            // t0
    b_start = 0;
    ecnt = 0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      ev = (i == 4 || i == 9 || i == 14);
      check("cont_valid", 32'(b_valid), 32'(ev));
      check("cont_en", 32'(b_en), 32'(i < 15 && !ev));
      check("cont_busy", 32'(b_busy), 32'(i < 15));
      if (ev) begin
        ecnt++;
        check("cont_sample", 32'(b_sample), 32'(4'b0110));
        check("cont_cnt", 32'(b_cnt), ecnt);
      end
      if (i == 11) b_cont = 0;
    end

    // Frame counter wrap, FCW=2
    c_y = 4'b1001; c_cont = 1; c_start = 1;
    tick();            // t0
    c_start = 0;
    ecnt = 0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      ev = (i % 5 == 4) && (i < 20);
      check("wrap_valid", 32'(c_valid), 32'(ev));
      if (ev) begin
        ecnt++;
        check("wrap_cnt", 32'(c_cnt), ecnt % 4);
        check("wrap_sample", 32'(c_sample), 32'(4'b1001));
      end
      if (i == 18) c_cont = 0;
    end
    check("wrap_final_cnt", 32'(c_cnt), 0);
    check("wrap_idle", 32'(c_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
